// File: rtl/tick_timer.sv
// tick_timer: syncs divider waves into clk-domain pulses, runs a seconds countdown, emits step.
// Optional low-time warning output is built only when TICK_TIMER_WARN_EN is defined.
module tick_timer #(
  parameter int SEC_W     = 8,
  parameter int START_SEC = 60,
  parameter int WARN_SEC  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div_1,
  input  logic             clk_div_2,
  input  logic             clk_div_3,
  input  logic [1:0]       level,
  input  logic             start,
  input  logic             pause,
  output logic [SEC_W-1:0] time_left,
  output logic             step,
  output logic [1:0]       state,
  output logic             done,
  output logic             warn
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [SEC_W-1:0] START_V = SEC_W'(START_SEC);
  localparam logic [SEC_W-1:0] ONE_V   = SEC_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       div_w;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       edge_q;
  logic [2:0]       rise_q;
  logic             any1_q;
  logic             step_src;
  logic             last_sec;
  logic [SEC_W-1:0] time_d;
  logic             step_d;
  logic             done_d;

  assign div_w    = {clk_div_3, clk_div_2, clk_div_1};
  assign last_sec = (time_left <= ONE_V);
  assign state    = state_q;

  // two-flop sync, edge register, then registered edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
      rise_q  <= '0;
      any1_q  <= 1'b0;
    end else begin
      sync1_q <= div_w;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      rise_q  <= sync2_q & ~edge_q;
      any1_q  <= sync2_q[0] ^ edge_q[0];
    end
  end

  // level picks which edge pulse drives step
  always_comb begin
    step_src = 1'b0;
    unique case (level)
      2'd0: step_src = rise_q[2];
      2'd1: step_src = rise_q[1];
      2'd2: step_src = rise_q[0];
      2'd3: step_src = any1_q;
      default: step_src = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state; the final second beats a same-cycle pause
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (rise_q[0] && last_sec) state_d = DONE;
        else if (pause)            state_d = PAUSE;
      end
      PAUSE: if (pause) state_d = RUN;
      DONE:  if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    time_d = time_left;
    step_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: time_d = START_V;
      RUN: begin
        step_d = step_src;
        if (rise_q[0]) begin
          if (last_sec) begin
            time_d = '0;
            done_d = 1'b1;
          end else begin
            time_d = time_left - ONE_V;
          end
        end
      end
      PAUSE: time_d = time_left;
      DONE:  time_d = start ? START_V : '0;
      default: time_d = START_V;
    endcase
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_left <= START_V;
      step      <= 1'b0;
      done      <= 1'b0;
    end else begin
      time_left <= time_d;
      step      <= step_d;
      done      <= done_d;
    end
  end

`ifdef TICK_TIMER_WARN_EN
  localparam logic [SEC_W-1:0] WARN_V = SEC_W'(WARN_SEC);

  logic warn_d;

  // warn follows the value time_left is about to take
  always_comb begin
    warn_d = 1'b0;
    if ((state_d == RUN) || (state_d == PAUSE))
      warn_d = (time_d != '0) && (time_d <= WARN_V);
  end

  // warn register, aligned with time_left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) warn <= 1'b0;
    else     warn <= warn_d;
  end
`else
  // feature not built; the term folds to a constant 0
  assign warn = 1'b0 && (WARN_SEC != 0);
`endif

endmodule

// File: doc/tick_timer.md
# tick_timer

Countdown timer and step-pulse generator that sits directly downstream of the clock divider. It synchronizes and edge-detects the three divided square waves into single-cycle enables in the `clk` domain. It runs a seconds countdown off the 1 s base tick and emits a level-dependent `step` pulse for game logic. All logic runs on `clk`; the divided signals are never used as clocks.

## Interface
- `SEC_W`, 8: width of `time_left`.
- `START_SEC`, 60: value loaded into `time_left` on reset, in IDLE, and on restart.
- `WARN_SEC`, 10: warning threshold, used only with `TICK_TIMER_WARN_EN`.
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `clk_div_1` input 1: divider square wave; one rising edge per second.
- `clk_div_2` input 1: divider square wave; slower than `clk_div_1`.
- `clk_div_3` input 1: divider square wave; slowest.
- `level` input 2: speed select for `step`.
- `start` input 1: single-cycle start/restart pulse.
- `pause` input 1: single-cycle pause/resume toggle pulse.
- `time_left` output SEC_W: remaining seconds.
- `step` output 1: single-cycle pulse at the rate selected by `level`; asserted only in RUN.
- `state` output 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `done` output 1: single-cycle pulse on entry to DONE.
- `warn` output 1: low-time indicator.

## Operation
- Each `clk_div_x` passes through a 2-flop synchronizer and then an edge register.
- `rise_x` is a one-cycle pulse on each 0→1 transition; `any_1` is a one-cycle pulse on either transition of `clk_div_1`.
- Step source selected by `level`:
  - 0 → `rise_3`
  - 1 → `rise_2`
  - 2 → `rise_1`
  - 3 → `any_1` (twice per second)
- `level` is sampled combinationally each cycle, so a change takes effect on the next qualifying edge.
- FSM states and transitions:
  - IDLE: `time_left`=START_SEC. `start` → RUN.
  - RUN:
    - On `rise_1`: `time_left` decrements.
    - If `time_left`==1 at `rise_1`: `time_left` becomes 0, go to DONE, pulse `done`.
    - `pause` → PAUSE.
    - `start` is ignored.
  - PAUSE: `time_left` frozen, no `step`. `pause` → RUN. `start` is ignored.
  - DONE: `time_left` held at 0. `start` reloads START_SEC → RUN.
- Simultaneous events in RUN:
  - `pause` with `rise_1`: the decrement and `step` are applied, then the FSM goes to PAUSE.
  - Final `rise_1` with `pause`: DONE wins.
- `time_left` never wraps below 0.
- START_SEC=0 is legal: `start` goes to RUN, and the first `rise_1` forces DONE with `time_left`=0.
- Edge pulses produced in IDLE or DONE are discarded. A spurious edge right after reset (input already high) is therefore harmless.

## Timing
- Reset values:
  - `state`=IDLE, `time_left`=START_SEC.
  - `step`=0, `done`=0, `warn`=0.
  - All synchronizer and edge flops are 0.
- `rise_x` is internal, asserted on the 3rd `clk` edge after the input transition is first sampled.
- `step`, `time_left` update, and `done` are registered: visible 1 cycle after `rise_x`, i.e. 4 cycles after input transition.
- `start` and `pause` act on the edge where they are high; `state` changes on the next cycle.
- `rst` asserted mid-RUN clears immediately, asynchronously; any pending edges are lost.
- Minimum input high/low time is 2 `clk` cycles. The divider guarantees far more.

## Configuration
- `TICK_TIMER_WARN_EN` defined:
  - `warn` is registered high while `state`∈{RUN, PAUSE} and 0<`time_left`≤WARN_SEC.
  - `warn` is cleared in IDLE and DONE.
  - It updates in the same cycle as `time_left`.
- Not defined: `warn` is tied to 0 and no compare logic is built.

## Test plan
- Reset with all `clk_div_x` high, no `start` → `state`=0, `time_left`=60, no `step`/`done` for 1000 cycles.
- START_SEC=3, `level`=2, `start`, then 3 `clk_div_1` rising edges → `time_left` 2,1,0, each 4 cycles after its edge; `done` single pulse with the third; `state`=3; a 4th edge changes nothing.
- `level`=3, RUN, 2 full `clk_div_1` periods → 4 `step` pulses. `level`=0 with 5 `clk_div_3` rises → exactly 5 `step` pulses.
- `pause` in the same cycle as `rise_1` → decrement applied, `state`=2. Further edges give no `step`. Second `pause` → `state`=1, counting resumes.
- `rst` pulsed mid-RUN with `time_left`=17 → immediate `time_left`=60, `state`=0. `start` in DONE → reload 60, `state`=1.
- With `TICK_TIMER_WARN_EN`, WARN_SEC=2, START_SEC=4 → `warn` rises when `time_left`=2 and drops when `time_left`=0/DONE. Without the macro → `warn` stays 0 throughout.
